sha_access_arbiter: RTL

//  Shares the single SHA-256 core among NREQ requesters (e.g. secure boot control, lifecycle protection).

---
 rtl/sha_access_arbiter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sha_access_arbiter.sv
// Shares one SHA-256 core among NREQ requesters: round-robin pick, session lock
// across multi-block hashes, init/next sequencing and a core-timeout abort.
module sha_access_arbiter #(
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 1024,
   parameter int TO_W    = 11
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ-1:0]      req_first,
   input  logic [NREQ-1:0]      req_last,
   input  logic [NREQ-1:0]      req_mode,
   input  logic [NREQ*512-1:0]  req_block,
   output logic [NREQ-1:0]      req_accept,
   output logic [NREQ-1:0]      resp_valid,
   output logic [NREQ-1:0]      resp_error,
   output logic [255:0]         resp_digest,
   output logic [NREQ-1:0]      grant,
   output logic                 busy,
   output logic [511:0]         sha_block,
   output logic                 sha_init,
   output logic                 sha_next,
   output logic                 sha_sel,
   input  logic                 sha_ready,
   input  logic                 sha_digest_valid,
   input  logic [255:0]         sha_digest
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

   state_t          state_reg, state_next;
   logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [IW-1:0]   owner_reg, owner_next;
   logic            first_reg, first_next;
   logic            last_reg, last_next;
   logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
   logic [NREQ-1:0] accept_reg, accept_next;
   logic [NREQ-1:0] valid_reg, valid_next;
   logic [NREQ-1:0] error_reg, error_next;
   logic [NREQ-1:0] grant_reg, grant_next;
   logic [255:0]    digest_reg, digest_next;
   logic [511:0]    block_reg, block_next;
   logic            init_reg, init_next;
   logic            cont_reg, cont_next;
   logic            sel_reg, sel_next;

   logic            lock;
   logic [IW-1:0]   cand_idx [NREQ];
   logic [NREQ-1:0] cand_valid;
   logic [511:0]    blk_arr [NREQ];
   logic            sel_found;
   logic [IW-1:0]   sel_idx;
   logic [NREQ-1:0] sel_onehot;

   // A session is locked exactly while some requester holds the grant.
   assign lock = |grant_reg;

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      logic [IW:0] sum_w;
      assign sum_w          = {1'b0, rr_ptr_reg} + (IW+1)'(gi + 1);
      assign cand_idx[gi]   = (sum_w >= (IW+1)'(NREQ)) ? IW'(sum_w - (IW+1)'(NREQ))
                                                       : sum_w[IW-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
      assign blk_arr[gi]    = req_block[gi*512 +: 512];
   end

   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      if (lock) begin
         sel_found = req_valid[owner_reg];
         sel_idx   = owner_reg;
      end else begin
         // Scan from the far end so the nearest candidate after rr_ptr wins.
         for (int k = NREQ - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
               sel_found = 1'b1;
               sel_idx   = cand_idx[k];
            end
         end
      end
   end

   assign sel_onehot = NREQ'(1) << sel_idx;

   always_comb begin
      state_next  = state_reg;
      rr_ptr_next = rr_ptr_reg;
      owner_next  = owner_reg;
      first_next  = first_reg;
      last_next   = last_reg;
      to_cnt_next = to_cnt_reg;
      accept_next = '0;
      valid_next  = '0;
      error_next  = '0;
      grant_next  = grant_reg;
      digest_next = digest_reg;
      block_next  = block_reg;
      init_next   = 1'b0;
      cont_next   = 1'b0;
      sel_next    = sel_reg;
      case (state_reg)
         IDLE: begin
            // accept_reg masks the cycle in which the requester is still seeing its pulse.
            if (sel_found && (accept_reg == '0)) begin
               accept_next = sel_onehot;
               if (!lock && !req_first[sel_idx]) begin
                  error_next = sel_onehot;
               end else begin
                  block_next = blk_arr[sel_idx];
                  sel_next   = req_mode[sel_idx];
                  first_next = req_first[sel_idx];
                  last_next  = req_last[sel_idx];
                  owner_next = sel_idx;
                  grant_next = sel_onehot;
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (sha_ready) begin
               init_next   = first_reg;
               cont_next   = !first_reg;
               to_cnt_next = '0;
               state_next  = WAIT_START;
            end
         end
         WAIT_START, WAIT_DONE: begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
            if ((state_reg == WAIT_DONE) && sha_ready && sha_digest_valid) begin
               digest_next = sha_digest;
               state_next  = RESP;
            end else if (to_cnt_reg == TO_W'(TIMEOUT - 1)) begin
               error_next  = grant_reg;
               grant_next  = '0;
               rr_ptr_next = owner_reg;
               state_next  = IDLE;
            end else if ((state_reg == WAIT_START) && !sha_ready) begin
               state_next = WAIT_DONE;
            end
         end
         RESP: begin
            valid_next = grant_reg;
            if (last_reg) begin
               grant_next  = '0;
               rr_ptr_next = owner_reg;
            end
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
         first_reg  <= 1'b0;
         last_reg   <= 1'b0;
         to_cnt_reg <= '0;
         accept_reg <= '0;
         valid_reg  <= '0;
         error_reg  <= '0;
         grant_reg  <= '0;
         digest_reg <= '0;
         block_reg  <= '0;
         init_reg   <= 1'b0;
         cont_reg   <= 1'b0;
         sel_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         owner_reg  <= owner_next;
         first_reg  <= first_next;
         last_reg   <= last_next;
         to_cnt_reg <= to_cnt_next;
         accept_reg <= accept_next;
         valid_reg  <= valid_next;
         error_reg  <= error_next;
         grant_reg  <= grant_next;
         digest_reg <= digest_next;
         block_reg  <= block_next;
         init_reg   <= init_next;
         cont_reg   <= cont_next;
         sel_reg    <= sel_next;
      end
   end

   assign req_accept  = accept_reg;
   assign resp_valid  = valid_reg;
   assign resp_error  = error_reg;
   assign resp_digest = digest_reg;
   assign grant       = grant_reg;
   assign busy        = (state_reg != IDLE);
   assign sha_block   = block_reg;
   assign sha_init    = init_reg;
   assign sha_next    = cont_reg;
   assign sha_sel     = sel_reg;

endmodule
